// File: rtl/rvfi_pkg.sv
// Retirement trace record layout shared by the retire queue and its RAM.
package rvfi_pkg;

  localparam int RVFI_REC_W   = 307;
  localparam int RVFI_ORDER_W = 64;

  // Field order is MSB to LSB; the widths must add up to RVFI_REC_W.
  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_rec_t;

endpackage

// File: rtl/retq_ram.sv
// Record storage for the retire queue: one write port and NRET
// combinational read ports, so several lanes can be shown in one cycle.
module retq_ram
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NRET  = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [RVFI_REC_W-1:0]      wdata_i,
  input  logic [NRET*AW-1:0]         raddr_i,
  output logic [NRET*RVFI_REC_W-1:0] rdata_o
);

  logic [RVFI_REC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar gi = 0; gi < NRET; gi++) begin : g_rd
    assign rdata_o[gi*RVFI_REC_W +: RVFI_REC_W] = mem_q[raddr_i[gi*AW +: AW]];
  end

endmodule

// File: rtl/rvfi_retire_queue.sv
// Retirement trace FIFO presenting up to NRET ordered records per cycle.
// Define RETQ_BYPASS_EN to let an empty queue forward the input to lane 0.
module rvfi_retire_queue
  import rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  input  logic [RVFI_REC_W-1:0]        in_rec_i,
  output logic                         in_ready_o,
  output logic [NRET-1:0]              out_valid_o,
  output logic [NRET*RVFI_REC_W-1:0]   out_rec_o,
  output logic [NRET*RVFI_ORDER_W-1:0] out_order_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [$clog2(DEPTH):0]       max_fill_o,
  output logic                         overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (XLEN != 32 || NRET < 1 || NRET > 4 || DEPTH < NRET || (1 << AW) != DEPTH) begin : g_bad_cfg
    $error("rvfi_retire_queue: unsupported XLEN/NRET/DEPTH combination");
  end

  logic [AW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d, max_fill_q, max_fill_d;
  logic [CW-1:0]           lanes_k, pop_k;
  logic [RVFI_ORDER_W-1:0] order_q, order_d;
  logic                    overflow_q, overflow_d;
  logic                    push, bypass_show, bypass_take;
  logic [NRET*AW-1:0]      raddr;
  logic [NRET*RVFI_REC_W-1:0] ram_rdata;

  assign lanes_k    = (count_q < CW'(NRET)) ? count_q : CW'(NRET);
  assign in_ready_o = (count_q < CW'(DEPTH));

`ifdef RETQ_BYPASS_EN
  assign bypass_show = (count_q == '0) & in_valid_i;
  assign bypass_take = bypass_show & out_ready_i;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A bypassed record is consumed straight from the input and never stored.
  assign push  = in_valid_i & in_ready_o & ~bypass_take;
  assign pop_k = out_ready_i ? lanes_k : '0;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + pop_k[AW-1:0];
    wr_ptr_d   = wr_ptr_q + AW'(push);
    count_d    = count_q + CW'(push) - pop_k;
    order_d    = order_q + RVFI_ORDER_W'(pop_k) + RVFI_ORDER_W'(bypass_take);
    max_fill_d = (count_d > max_fill_q) ? count_d : max_fill_q;
    overflow_d = overflow_q | (in_valid_i & ~in_ready_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      order_q    <= '0;
      max_fill_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      order_q    <= order_d;
      max_fill_q <= max_fill_d;
      overflow_q <= overflow_d;
    end
  end

  retq_ram #(
    .DEPTH (DEPTH),
    .NRET  (NRET),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_rec_i),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
    logic lane_on;
    logic [RVFI_REC_W-1:0] lane_rec;

    assign lane_on  = (CW'(gi) < lanes_k);
    assign lane_rec = lane_on ? ram_rdata[gi*RVFI_REC_W +: RVFI_REC_W] : '0;
    assign raddr[gi*AW +: AW] = rd_ptr_q + AW'(gi);
    assign out_order_o[gi*RVFI_ORDER_W +: RVFI_ORDER_W] = order_q + RVFI_ORDER_W'(gi);

    if (gi == 0) begin : g_l0
      assign out_valid_o[gi] = lane_on | bypass_show;
      assign out_rec_o[gi*RVFI_REC_W +: RVFI_REC_W] = bypass_show ? in_rec_i : lane_rec;
    end else begin : g_ln
      assign out_valid_o[gi] = lane_on;
      assign out_rec_o[gi*RVFI_REC_W +: RVFI_REC_W] = lane_rec;
    end
  end

  assign count_o    = count_q;
  assign max_fill_o = max_fill_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rvfi_retire_queue.sv
// Randomised and directed scoreboard bench for rvfi_retire_queue.
module tb_rvfi_retire_queue;
  import rvfi_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         in_valid_i = 1'b0;
  logic [RVFI_REC_W-1:0]        in_rec_i = '0;
  logic                         in_ready_o;
  logic [NRET-1:0]              out_valid_o;
  logic [NRET*RVFI_REC_W-1:0]   out_rec_o;
  logic [NRET*RVFI_ORDER_W-1:0] out_order_o;
  logic                         out_ready_i = 1'b0;
  logic [CW-1:0]                count_o, max_fill_o;
  logic                         overflow_o;

  int total = 0;
  int bad   = 0;

  rvfi_retire_queue #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_rec_i    (in_rec_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_rec_o   (out_rec_o),
    .out_order_o (out_order_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o),
    .max_fill_o  (max_fill_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored records plus the next order number.
  logic [RVFI_REC_W-1:0] exp_q[$];
  longint unsigned       next_order;
  int                    m_max;
  bit                    m_ovf;
  int                    sz, kk;
  bit                    byp;
  int                    n_txn = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      next_order = 0;
      m_max      = 0;
      m_ovf      = 0;
    end else begin
      sz  = exp_q.size();
      kk  = (sz < NRET) ? sz : NRET;
      byp = 0;
`ifdef RETQ_BYPASS_EN
      byp = (sz == 0) && in_valid_i;
`endif
      chk("in_ready", 320'(in_ready_o), 320'(sz < DEPTH));
      chk("count", 320'(count_o), 320'(sz));
      chk("max_fill", 320'(max_fill_o), 320'(m_max));
      chk("overflow", 320'(overflow_o), 320'(m_ovf));
      for (int i = 0; i < NRET; i++) begin
        logic [RVFI_REC_W-1:0] er;
        logic                  ev;
        ev = (i < kk) || (i == 0 && byp);
        er = '0;
        if (i == 0 && byp) er = in_rec_i;
        else if (i < kk)   er = exp_q[i];
        chk($sformatf("valid%0d", i), 320'(out_valid_o[i]), 320'(ev));
        chk($sformatf("rec%0d", i), 320'(out_rec_o[i*RVFI_REC_W +: RVFI_REC_W]), 320'(er));
        chk($sformatf("order%0d", i), 320'(out_order_o[i*64 +: 64]), 320'(next_order + longint'(i)));
      end
      if (byp && out_ready_i) begin
        next_order++;
        n_txn++;
        $display("txn %0d: bypass order=%0d", n_txn, next_order - 1);
      end else begin
        if (out_ready_i && kk > 0) begin
          for (int i = 0; i < kk; i++) void'(exp_q.pop_front());
          next_order += longint'(kk);
          n_txn++;
          $display("txn %0d: pop %0d lanes, next order=%0d", n_txn, kk, next_order);
        end
        if (in_valid_i && sz < DEPTH) exp_q.push_back(in_rec_i);
      end
      if (in_valid_i && sz >= DEPTH) m_ovf = 1;
      if (exp_q.size() > m_max) m_max = exp_q.size();
    end
  end

  function automatic logic [RVFI_REC_W-1:0] mk(input logic [31:0] insn);
    logic [319:0] t;
    rvfi_rec_t r;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom};
    r = t[RVFI_REC_W-1:0];
    r.insn = insn;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [RVFI_REC_W-1:0] r, input logic ordy);
    @(posedge clk);
    #1;
    in_valid_i  = v;
    in_rec_i    = r;
    out_ready_i = ordy;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);
    repeat (2) drive(1'b0, '0, 1'b0);

    // Three records held, then drained over two cycles.
    drive(1'b1, mk(32'h00100093), 1'b0);
    drive(1'b1, mk(32'h00200113), 1'b0);
    drive(1'b1, mk(32'h00300193), 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1);

    // Fill to DEPTH and offer extra records to hit overflow.
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, mk(32'h1000 + 32'(i)), 1'b0);
    // Full queue: pop and push offer together; push must be refused.
    drive(1'b1, mk(32'hdead0001), 1'b1);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, mk(32'hdead0002), 1'b0);
    repeat (6) drive(1'b0, '0, 1'b1);

    // Streaming with the consumer always ready; pointers wrap several times.
    for (int i = 0; i < 40; i++) drive(1'b1, mk(32'h2000 + 32'(i)), 1'b1);
    repeat (3) drive(1'b0, '0, 1'b1);

    // Reset in the middle of operation discards contents and restarts ordering.
    for (int i = 0; i < 5; i++) drive(1'b1, mk(32'h3000 + 32'(i)), 1'b0);
    do_reset(1);
    drive(1'b1, mk(32'h4000), 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 2) != 0), mk($urandom), ($urandom_range(0, 2) == 0));
    repeat (8) drive(1'b0, '0, 1'b1);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
